// File: rtl/if_pkg.sv
// Shared widths, bus signal levels and fetch FSM states for the IF stage.
// Build option IF_PREFETCH_BUF_EN enables the one-entry prefetch buffer.
package if_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;

    typedef enum logic [1:0] {
        IF_IDLE   = 2'd0,
        IF_REQ    = 2'd1,
        IF_ACCESS = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_bus_if.sv
// Fetch bus master: request/grant/strobe/ready FSM, bus outputs and busy.
module if_bus_if
    import if_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              br_taken,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc,
    input  logic              bus_grnt_,
    input  logic              bus_rdy_,
    output logic              busy,
    output logic              bus_req_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              rd_done
);

    if_state_t state;
    if_state_t next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IF_IDLE;
        end else begin
            state <= next;
        end
    end

    assign bus_rw = READ;

    always_comb begin
        next     = state;
        busy     = 1'b0;
        bus_req_ = DISABLE_;
        bus_as_  = DISABLE_;
        bus_addr = '0;
        rd_done  = 1'b0;
        unique case (state)
            IF_IDLE: begin
                if (!stall && fetch_en) begin
                    next = IF_REQ;
                end
            end
            IF_REQ: begin
                bus_req_ = ENABLE_;
                busy     = 1'b1;
                if (bus_grnt_ == ENABLE_) begin
                    next = IF_ACCESS;
                end
            end
            IF_ACCESS: begin
                bus_req_ = ENABLE_;
                bus_as_  = ENABLE_;
                bus_addr = pc;
                if (bus_rdy_ == ENABLE_) begin
                    rd_done = 1'b1;
                    next    = IF_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: next = IF_IDLE;
        endcase
        // redirects abort whatever access is in progress
        if (flush || (br_taken && !stall)) begin
            next = IF_IDLE;
        end
    end

endmodule

// File: rtl/if_top.sv
// Instruction-fetch stage: fetch PC, IF/ID register, bus master instance.
// Build option IF_PREFETCH_BUF_EN keeps a word read during stall.
module if_top
    import if_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 30'h0000_0000,
    parameter logic [DATA_W-1:0] NOP_INSN     = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              busy,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_rdy_,
    input  logic [DATA_W-1:0] bus_rd_data,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_insn,
    output logic              if_en
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] load_pc;
    logic [DATA_W-1:0] load_insn;
    logic              rd_done;
    logic              fetch_en;
    logic              pc_adv;
    logic              load;
    logic              redirect;

    assign pc_inc   = pc + ADDR_W'(1);
    assign redirect = flush | (br_taken & ~stall);

`ifdef IF_PREFETCH_BUF_EN
    logic              buf_valid;
    logic [DATA_W-1:0] buf_insn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_insn  <= NOP_INSN;
        end else if (redirect) begin
            buf_valid <= 1'b0;
        end else if (stall) begin
            if (rd_done) begin
                buf_valid <= 1'b1;
                buf_insn  <= bus_rd_data;
            end
        end else begin
            buf_valid <= 1'b0;
        end
    end

    // pc already points past the buffered word once it is captured
    assign fetch_en  = ~buf_valid;
    assign pc_adv    = rd_done;
    assign load      = ~stall & (rd_done | buf_valid);
    assign load_pc   = buf_valid ? pc : pc_inc;
    assign load_insn = buf_valid ? buf_insn : bus_rd_data;
`else
    assign fetch_en  = 1'b1;
    assign pc_adv    = rd_done & ~stall;
    assign load      = rd_done & ~stall;
    assign load_pc   = pc_inc;
    assign load_insn = bus_rd_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else if (flush) begin
            pc <= new_pc;
        end else if (br_taken && !stall) begin
            pc <= br_addr;
        end else if (pc_adv) begin
            pc <= pc_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_pc   <= '0;
            if_insn <= NOP_INSN;
            if_en   <= 1'b0;
        end else if (redirect) begin
            if_insn <= NOP_INSN;
            if_en   <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                if_pc   <= load_pc;
                if_insn <= load_insn;
                if_en   <= 1'b1;
            end else begin
                if_insn <= NOP_INSN;
                if_en   <= 1'b0;
            end
        end
    end

    if_bus_if u_bus (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .br_taken  (br_taken),
        .fetch_en  (fetch_en),
        .pc        (pc),
        .bus_grnt_ (bus_grnt_),
        .bus_rdy_  (bus_rdy_),
        .busy      (busy),
        .bus_req_  (bus_req_),
        .bus_as_   (bus_as_),
        .bus_rw    (bus_rw),
        .bus_addr  (bus_addr),
        .rd_done   (rd_done)
    );

endmodule

// File: tb/tb_if_top.sv
// Testbench for if_top: directed scenarios plus random traffic vs a model.
module tb_if_top;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [29:0] new_pc = '0;
    logic        br_taken = 1'b0;
    logic [29:0] br_addr = '0;
    logic        bus_grnt_ = 1'b1;
    logic        bus_rdy_ = 1'b1;
    logic [31:0] bus_rd_data = '0;
    logic        busy;
    logic        bus_req_;
    logic        bus_as_;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;

    int checks = 0;
    int failures = 0;

    // reference model: phase 0 idle, 1 requesting, 2 accessing
    int          m_ph;
    logic [29:0] m_pc;
    logic [29:0] m_if_pc;
    logic [31:0] m_insn;
    logic [31:0] m_bd;
    bit          m_en;
    bit          m_bv;

    if_top dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .br_taken    (br_taken),
        .br_addr     (br_addr),
        .busy        (busy),
        .bus_req_    (bus_req_),
        .bus_grnt_   (bus_grnt_),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_addr    (bus_addr),
        .bus_rdy_    (bus_rdy_),
        .bus_rd_data (bus_rd_data),
        .if_pc       (if_pc),
        .if_insn     (if_insn),
        .if_en       (if_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return 32'h1234_5678 + 32'(a) * 32'h0101_0101;
    endfunction

    task automatic model_reset();
        m_ph = 0;
        m_pc = '0;
        m_if_pc = '0;
        m_insn = NOP;
        m_bd = NOP;
        m_en = 0;
        m_bv = 0;
    endtask

    task automatic model_step();
        bit done;
        done = (m_ph == 2) && !bus_rdy_;
        if (flush) begin
            m_pc = new_pc;
            m_en = 0;
            m_insn = NOP;
            m_bv = 0;
            m_ph = 0;
        end else if (br_taken && !stall) begin
            m_pc = br_addr;
            m_en = 0;
            m_insn = NOP;
            m_bv = 0;
            m_ph = 0;
        end else begin
            if (m_ph == 0) m_ph = (!stall && !m_bv) ? 1 : 0;
            else if (m_ph == 1) m_ph = !bus_grnt_ ? 2 : 1;
            else m_ph = done ? 0 : 2;
            if (stall) begin
`ifdef IF_PREFETCH_BUF_EN
                if (done) begin
                    m_bd = bus_rd_data;
                    m_bv = 1;
                    m_pc = m_pc + 30'd1;
                end
`endif
            end else if (m_bv) begin
                m_insn = m_bd;
                m_if_pc = m_pc;
                m_en = 1;
                m_bv = 0;
            end else if (done) begin
                m_insn = bus_rd_data;
                m_if_pc = m_pc + 30'd1;
                m_en = 1;
                m_pc = m_pc + 30'd1;
            end else begin
                m_en = 0;
                m_insn = NOP;
            end
        end
    endtask

    task automatic tick();
        #1;
        check("busy", busy, (m_ph == 1) || (m_ph == 2 && bus_rdy_));
        check("bus_req_", bus_req_, m_ph == 0);
        check("bus_as_", bus_as_, m_ph != 2);
        check("bus_rw", bus_rw, 1'b1);
        check("bus_addr", bus_addr, (m_ph == 2) ? m_pc : 30'd0);
        check("if_pc", if_pc, m_if_pc);
        check("if_insn", if_insn, m_insn);
        check("if_en", if_en, m_en);
        model_step();
        @(negedge clk);
    endtask

    task automatic go(input logic s, input logic f, input logic [29:0] np,
                      input logic b, input logic [29:0] ba,
                      input logic g, input logic r);
        stall = s;
        flush = f;
        new_pc = np;
        br_taken = b;
        br_addr = ba;
        bus_grnt_ = g;
        bus_rdy_ = r;
        bus_rd_data = mem_word(bus_addr);
        tick();
    endtask

    initial begin
        int upd;
        model_reset();
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_req", bus_req_, 1'b1);
        check("rst_as", bus_as_, 1'b1);
        check("rst_rw", bus_rw, 1'b1);
        check("rst_addr", bus_addr, 30'd0);
        check("rst_if_pc", if_pc, 30'd0);
        check("rst_insn", if_insn, NOP);
        check("rst_en", if_en, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // zero-wait fetch from reset vector
        repeat (3) go(0, 0, 0, 0, 0, 0, 0);
        check("t1_insn", if_insn, 32'h1234_5678);
        check("t1_pc", if_pc, 30'd1);
        check("t1_en", if_en, 1'b1);
        go(0, 0, 0, 0, 0, 0, 1);
        go(0, 0, 0, 0, 0, 0, 1);
        check("t1_next_addr", bus_addr, 30'd1);
        go(0, 0, 0, 0, 0, 1, 0);

        // grant withheld then two wait states
        go(0, 1, 30'h8, 0, 0, 1, 1);
        upd = 0;
        go(0, 0, 0, 0, 0, 1, 1);
        repeat (4) begin
            go(0, 0, 0, 0, 0, 1, 1);
            check("t2_busy_req", busy, 1'b1);
            if (if_en) upd++;
        end
        go(0, 0, 0, 0, 0, 0, 1);
        repeat (2) begin
            if (if_en) upd++;
            go(0, 0, 0, 0, 0, 1, 1);
        end
        go(0, 0, 0, 0, 0, 1, 0);
        if (if_en) upd++;
        go(0, 0, 0, 0, 0, 1, 1);
        if (if_en) upd++;
        check("t2_updates", upd, 1);

        // branch during access drops the returned word
        go(0, 1, 30'h10, 0, 0, 1, 1);
        go(0, 0, 0, 0, 0, 0, 1);
        go(0, 0, 0, 0, 0, 0, 1);
        go(0, 0, 0, 1, 30'h100, 0, 0);
        check("t3_en", if_en, 1'b0);
        go(0, 0, 0, 0, 0, 0, 1);
        go(0, 0, 0, 0, 0, 0, 1);
        check("t3_addr", bus_addr, 30'h100);

        // flush outranks branch
        go(0, 1, 30'h40, 1, 30'h80, 1, 1);
        go(0, 0, 0, 0, 0, 0, 1);
        go(0, 0, 0, 0, 0, 0, 1);
        check("t4_addr", bus_addr, 30'h40);

        // ready arrives while stalled at address 5
        go(0, 1, 30'h5, 0, 0, 1, 1);
        go(0, 0, 0, 0, 0, 0, 1);
        go(1, 0, 0, 0, 0, 0, 1);
        go(1, 0, 0, 0, 0, 1, 0);
        go(1, 0, 0, 0, 0, 1, 1);
        go(0, 0, 0, 0, 0, 1, 1);
`ifdef IF_PREFETCH_BUF_EN
        check("t5_buf_en", if_en, 1'b1);
        check("t5_buf_pc", if_pc, 30'd6);
        check("t5_buf_insn", if_insn, mem_word(30'd5));
        go(0, 0, 0, 0, 0, 0, 1);
        go(0, 0, 0, 0, 0, 0, 1);
        check("t5_next_addr", bus_addr, 30'd6);
`else
        check("t5_en", if_en, 1'b0);
        go(0, 0, 0, 0, 0, 0, 1);
        check("t5_refetch", bus_addr, 30'd5);
`endif

        // PC wraps at the top of the word space
        go(0, 1, 30'h3FFF_FFFF, 0, 0, 1, 1);
        repeat (3) go(0, 0, 0, 0, 0, 0, 0);
        check("t6_pc", if_pc, 30'd0);
        check("t6_en", if_en, 1'b1);
        check("t6_insn", if_insn, mem_word(30'h3FFF_FFFF));
        go(0, 0, 0, 0, 0, 0, 1);
        go(0, 0, 0, 0, 0, 0, 1);
        check("t6_next_addr", bus_addr, 30'd0);

        // asynchronous reset mid-access
        go(0, 1, 30'h20, 0, 0, 1, 1);
        go(0, 0, 0, 0, 0, 0, 1);
        go(0, 0, 0, 0, 0, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t7_req", bus_req_, 1'b1);
        check("t7_as", bus_as_, 1'b1);
        check("t7_busy", busy, 1'b0);
        check("t7_addr", bus_addr, 30'd0);
        check("t7_en", if_en, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // random traffic
        repeat (600) begin
            logic [29:0] np;
            logic [29:0] ba;
            np = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE + 30'($urandom_range(0, 1))
                                             : 30'($urandom);
            ba = 30'($urandom);
            go($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, np,
               $urandom_range(0, 11) == 0, ba,
               $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
